// File: rtl/aes_128_sched_pkg.sv
// Shared types and defaults for the AES-128 issue scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_LATENCY    = 21;
  localparam int unsigned AES_FIFO_DEPTH = 32;

  typedef logic [127:0] aes_blk_t;
  typedef logic         req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/aes_128_sched_if.sv
// Request, core and response signals of the AES-128 scheduler.
interface aes_128_sched_if;
  import aes_sched_pkg::*;

  logic     req0_valid;
  logic     req0_ready;
  aes_blk_t req0_state;
  aes_blk_t req0_key;
  logic     req1_valid;
  logic     req1_ready;
  aes_blk_t req1_state;
  aes_blk_t req1_key;
  aes_blk_t core_state;
  aes_blk_t core_key;
  aes_blk_t core_out;
  logic     rsp_valid;
  logic     rsp_ready;
  aes_blk_t rsp_data;
  req_id_t  rsp_id;
  logic     busy;

  // Environment side: requesters, core and response consumer
  modport master (
    output req0_valid, req0_state, req0_key,
    output req1_valid, req1_state, req1_key,
    output core_out, rsp_ready,
    input  req0_ready, req1_ready, core_state, core_key,
    input  rsp_valid, rsp_data, rsp_id, busy
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_state, req0_key,
    input  req1_valid, req1_state, req1_key,
    input  core_out, rsp_ready,
    output req0_ready, req1_ready, core_state, core_key,
    output rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/aes_128_sched_rsp_fifo.sv
// Synchronous response FIFO with a registered head entry.
module aes_rsp_fifo #(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned WIDTH = 129,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [CW-1:0]    remain;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

  // Pointer/count update and next head selection
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    remain   = count_q - CW'(pop_ok);
    // Head register mirrors the next head: bypass the incoming word when
    // the FIFO would otherwise be empty, else read the already-stored entry.
    if (count_d == '0) begin
      head_d = '0;
    end else if (remain == '0) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, count and head register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/aes_128_sched.sv
// Two-requester round-robin issue scheduler with credit-gated response buffer.
module aes_128_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned LATENCY    = AES_LATENCY,
  parameter int unsigned FIFO_DEPTH = AES_FIFO_DEPTH
) (
  input logic            clk,
  input logic            rst,
  aes_128_sched_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  req_id_t       rr_q, rr_d;
  logic [CW-1:0] inflight_q, inflight_d;
  tag_t          tags_q [LATENCY];
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [128:0]  fifo_head;
  logic          fifo_push;
  logic          credit;
  logic          grant0, grant1, issue;
  logic          last_valid;

  assign last_valid = tags_q[LATENCY-1].valid;
  assign fifo_push  = last_valid;

  // Arbitration, issue muxing and in-flight count
  always_comb begin
    credit = !fifo_full &&
             ((SW'(inflight_q) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
    grant0 = !rst && credit && bus.req0_valid &&
             (!bus.req1_valid || (rr_q == 1'b0));
    grant1 = !rst && credit && bus.req1_valid &&
             (!bus.req0_valid || (rr_q == 1'b1));
    issue  = grant0 || grant1;
    rr_d   = rr_q;
    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end
    bus.core_state = '0;
    bus.core_key   = '0;
    if (grant0) begin
      bus.core_state = bus.req0_state;
      bus.core_key   = bus.req0_key;
    end else if (grant1) begin
      bus.core_state = bus.req1_state;
      bus.core_key   = bus.req1_key;
    end
    inflight_d = inflight_q + CW'(issue) - CW'(last_valid);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Round-robin pointer, in-flight counter and tag shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      inflight_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      tags_q[0]  <= tag_t'{valid: issue, id: grant1};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tags_q[i] <= tags_q[i-1];
      end
    end
  end

  aes_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (129)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({tags_q[LATENCY-1].id, bus.core_out}),
    .pop_i       (bus.rsp_valid && bus.rsp_ready),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = fifo_head[128];
  assign bus.rsp_data  = fifo_head[127:0];
  assign bus.busy      = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed self-checking bench for aes_128_sched with an XOR core model.
module tb_aes_128_sched;
  import aes_sched_pkg::*;

  localparam int LAT   = 21;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_128_sched_if bus();

  aes_128_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core model: state ^ key delayed LAT cycles
  aes_blk_t pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= bus.core_state ^ bus.core_key;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.core_out = pipe[LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n0, n1, gcount, first_pop, first_g, lat;
  logic [128:0] pop_q [$];
  int pop_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic aes_blk_t blk_state(input int id, input int n);
    return {16'(id), 16'(n), 32'h0123_4567, 32'h89AB_CDEF, 32'(n * 7 + id)};
  endfunction

  function automatic aes_blk_t blk_key(input int id, input int n);
    return {4{32'hA5A5_0000 + 32'(id * 256 + n)}};
  endfunction

  function automatic logic [128:0] exp_rsp(input int id, input int n);
    return {1'(id), blk_state(id, n) ^ blk_key(id, n)};
  endfunction

  // Protocol monitor and response logger
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        pop_q.push_back({bus.rsp_id, bus.rsp_data});
        pop_cyc_q.push_back(cyc);
      end
      if (bus.req0_ready && bus.req1_ready) check("one_ready", 1, 0);
      if (bus.req0_ready && !bus.req0_valid) check("rdy0_no_valid", 1, 0);
      if (bus.req1_ready && !bus.req1_valid) check("rdy1_no_valid", 1, 0);
      if (dut.fifo_push && dut.fifo_full) check("push_full", 1, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input bit v1, input int a, input int b);
    bus.req0_valid = v0;
    bus.req0_state = blk_state(0, a);
    bus.req0_key   = blk_key(0, a);
    bus.req1_valid = v1;
    bus.req1_state = blk_state(1, b);
    bus.req1_key   = blk_key(1, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    pop_q.delete();
    pop_cyc_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;

    // Reset values, with both requesters valid during reset
    drive(1, 1, 0, 0);
    step();
    step();
    @(negedge clk);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_core_state", bus.core_state, 0);
    check("rst_core_key", bus.core_key, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);

    // Single request latency
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_state = 128'h00112233445566778899aabbccddeeff;
    bus.req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    check("t1_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    check("t1_core_state", bus.core_state, 128'h00112233445566778899aabbccddeeff);
    check("t1_core_key", bus.core_key, 128'h000102030405060708090a0b0c0d0e0f);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t1_idle_core", bus.core_state, 0);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      step();
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 22);
    check("t1_data", bus.rsp_data, 128'h00102030405060708090a0b0c0d0e0f0);
    check("t1_id", bus.rsp_id, 0);
    check("t1_busy", bus.busy, 1);
    step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("t1_drained_valid", bus.rsp_valid, 0);
    check("t1_drained_busy", bus.busy, 0);

    // Alternating grants with both requesters valid
    do_reset();
    bus.rsp_ready = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      drive(1, 1, n0, n1);
      @(negedge clk);
      check("t2_grant", {bus.req1_ready, bus.req0_ready}, (c % 2) ? 2'b10 : 2'b01);
      if (bus.req0_ready) n0++;
      if (bus.req1_ready) n1++;
    end
    step();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 60 && pop_q.size() < 8; k++) step();
    check("t2_count", pop_q.size(), 8);
    for (int i = 0; i < 8 && i < pop_q.size(); i++) begin
      check("t2_rsp", pop_q[i], exp_rsp(i % 2, i / 2));
      check("t2_no_bubble", pop_cyc_q[i] - pop_cyc_q[0], i);
    end

    // Backpressure: credit exhausts at FIFO_DEPTH, then drains and resumes
    do_reset();
    n0 = 0;
    n1 = 0;
    gcount = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) step();
      drive(1, 1, n0, n1);
      @(negedge clk);
      if (bus.req0_ready) begin n0++; gcount++; end
      if (bus.req1_ready) begin n1++; gcount++; end
    end
    check("t3_grants", gcount, 32);
    check("t3_stall", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("t3_full_count", dut.fifo_count, 32);
    first_pop = -1;
    first_g = -1;
    for (int c = 0; c < 40; c++) begin
      step();
      bus.rsp_ready = 1'b1;
      drive(1, 1, n0, n1);
      @(negedge clk);
      if (bus.rsp_valid && first_pop < 0) first_pop = c;
      if ((bus.req0_ready || bus.req1_ready) && first_g < 0) first_g = c;
      if (bus.req0_ready) n0++;
      if (bus.req1_ready) n1++;
    end
    check("t3_first_pop", first_pop, 0);
    check("t3_resume", first_g, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    check("t3_drain_count", pop_q.size() >= 32, 1);
    for (int i = 0; i < 32 && i < pop_q.size(); i++) begin
      check("t3_order", pop_q[i], exp_rsp(i % 2, i / 2));
    end

    // Push and pop in the same cycle keep the count
    do_reset();
    for (int c = 0; c < 28; c++) begin
      if (c > 0) step();
      bus.rsp_ready = (c == 26);
      drive(c < 6, 0, c, 0);
      @(negedge clk);
      if (c < 6) check("t4_grant", bus.req0_ready, 1);
      if (c == 26) check("t4_cnt_pre", dut.fifo_count, 5);
      if (c == 27) check("t4_cnt_post", dut.fifo_count, 5);
    end
    step();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20 && pop_q.size() < 6; k++) step();
    check("t4_count", pop_q.size(), 6);
    for (int i = 0; i < 6 && i < pop_q.size(); i++) begin
      check("t4_order", pop_q[i], exp_rsp(0, i));
    end

    // Reset with 10 in flight and 3 buffered
    do_reset();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) step();
      if (c == 24) begin
        check("t5_inflight", dut.inflight_q, 10);
        check("t5_buffered", dut.fifo_count, 3);
        rst = 1'b1;
        drive(1, 1, 50, 50);
      end else begin
        drive(c < 13, 0, c, 0);
      end
      @(negedge clk);
    end
    check("t5_rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t5_rsp_valid", bus.rsp_valid, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_core_state", bus.core_state, 0);
    check("t5_core_key", bus.core_key, 0);
    step();
    drive(1, 1, 100, 100);
    @(negedge clk);
    check("t5_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    step();
    drive(0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    repeat (40) step();
    check("t5_pop_count", pop_q.size(), 1);
    if (pop_q.size() > 0) check("t5_rsp", pop_q[0], exp_rsp(0, 100));

    // Single requester: consecutive grants to req1, pointer returns to 0
    do_reset();
    drive(1, 0, 0, 0);
    @(negedge clk);
    check("t6_pre_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    for (int c = 0; c < 4; c++) begin
      step();
      drive(0, 1, 0, c);
      @(negedge clk);
      check("t6_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    end
    step();
    drive(1, 1, 1, 9);
    @(negedge clk);
    check("t6_rr", dut.rr_q, 0);
    check("t6_next_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    step();
    drive(0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_128_sched.md
# aes_128_sched

Two-requester issue scheduler and response buffer for the pipelined AES-128 core. It round-robin arbitrates state/key requests from two clients and issues at most one block per cycle into the non-stallable core. A shift register tracks in-flight blocks and their requester IDs. Results are captured into an output FIFO with credit-based admission, so no result is ever dropped under response backpressure.

## Interface
- `LATENCY`, 21: cycles from a block presented on `core_state`/`core_key` to its result on `core_out`.
- `FIFO_DEPTH`, 32: response FIFO entries; power of two, ≥ 2; ≥ `LATENCY` for full throughput.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; also wired to the core.
- `req0_valid`  in  1  requester 0 has a block.
- `req0_ready`  out  1  requester 0 block accepted this cycle.
- `req0_state`  in  128  plaintext.
- `req0_key`  in  128  key.
- `req1_valid`, `req1_ready`, `req1_state`, `req1_key`: same as requester 0.
- `core_state`  out  128  to core `state`.
- `core_key`  out  128  to core `key`.
- `core_out`  in  128  core result.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  consumer accepts the head.
- `rsp_data`  out  128  ciphertext.
- `rsp_id`  out  1  originating requester.
- `busy`  out  1  any block in flight or buffered.

## Operation
- Credit is tracked as `inflight + fifo_count`, both registered counters of width $clog2(FIFO_DEPTH+1). Issue is allowed only when the sum is less than `FIFO_DEPTH`. A FIFO pop in the same cycle does not add credit until the next cycle (conservative).
- Arbiter:
  - `rr_ptr` names the preferred requester.
  - If both requesters are valid and credit is available, the preferred one is granted.
  - If only one is valid, that one is granted.
  - After any grant, `rr_ptr` becomes the non-granted requester index.
  - At most one `reqN_ready` is high per cycle. `reqN_ready` is combinational from valid, credit and `rr_ptr`, and is never high without the matching `reqN_valid`.
- Issue cycle: `core_state`/`core_key` = the granted request's fields. In all non-issue cycles they are driven to 0.
- Tracking: a `LATENCY`-deep shift register of {valid, id}. Stage 0 loads {issue, granted id}. When the last stage is valid, `core_out` and its id are written to the FIFO in that cycle.
- FIFO:
  - Synchronous, registered head.
  - `rsp_*` come from the head entry. Pop on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push into a full FIFO is impossible by construction. The bench asserts this never happens.
- `inflight` increments on issue and decrements when the last stage is valid. When both happen in the same cycle, it is unchanged.
- `busy` = `inflight != 0 || fifo_count != 0`.

## Timing
- Reset (also mid-operation) clears:
  - shift register, `inflight`, FIFO pointers and count;
  - `rr_ptr` := 0.
  - In-flight and buffered blocks are discarded.
- Reset output values: `req*_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0, `core_*` = 0.
- Issue at cycle t → result on `core_out` at t+`LATENCY` → FIFO write at end of that cycle → `rsp_valid` earliest at t+`LATENCY`+1.
- Throughput is one block per cycle while credit lasts. Responses come out in issue order.
- With `rsp_ready` = 0, issues stop after exactly `FIFO_DEPTH` accepted blocks.

## Structure
- Package `aes_sched_pkg`:
  - `AES_LATENCY` default constant;
  - `aes_blk_t` (128-bit) typedef;
  - `req_id_t` (1-bit) typedef;
  - `tag_t` struct {valid, id}.
- Sub-module `aes_rsp_fifo`: parameterised sync FIFO, 129-bit entries (data + id), full/empty/count outputs.
- The core itself is instantiated by the parent, not inside this block.

## Test plan
Bench core model: `core_out` = `state ^ key` delayed `LATENCY` cycles.
- Single request: req0 sends state=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f at t. Required: `rsp_valid` at t+22, `rsp_data`=0x00102030405060708090a0b0c0d0e0f0, `rsp_id`=0.
- Both requesters continuously valid for 8 cycles, `rsp_ready`=1. Required: grants alternate 0,1,0,1,…; 8 responses in issue order with ids 0,1,0,1,…; no bubbles.
- Backpressure: `rsp_ready`=0, both requesters always valid. Required: exactly 32 grants, then both `req*_ready` stay 0. Raise `rsp_ready`: 32 responses drain in order, then issue resumes one cycle after the first pop.
- Simultaneous push/pop: FIFO holding 5 entries, a result arriving while `rsp_ready`=1. Required: count stays 5; data order preserved.
- Reset mid-stream: assert `rst` with 10 in flight and 3 buffered. Required next cycle: `rsp_valid`=0, `busy`=0, `core_*`=0. The first post-reset grant goes to req0 when both are valid.
- Single requester: req1 alone valid for 4 cycles. Required: 4 consecutive grants to req1; `rr_ptr` ends at 0.
